// File: rtl/dmem_resp_if.sv
// Load/store request bus between the core (master) and the data-memory responder (slave).
interface dmem_resp_if;
    logic        MR;
    logic        MW;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        stall;
    logic        err;

    modport master (
        output MR, MW, func3, addr, wdata,
        input  rdata, ready, stall, err
    );

    modport slave (
        input  MR, MW, func3, addr, wdata,
        output rdata, ready, stall, err
    );
endinterface

// File: rtl/dmem_resp.sv
// Multicycle data-memory responder: byte/half/word loads and stores with RV32I extension.
//   state | meaning
//   IDLE  | waiting for MR/MW; stall follows the request combinationally
//   BUSY  | wait counter running; access happens on the edge where it reads 1
//   DONE  | one-cycle ready pulse with rdata/err valid
module dmem_resp #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input logic       clk_i,
    input logic       rst_i,
    dmem_resp_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                mr_q, mr_d, mw_q, mw_d;
    logic [2:0]          f3_q, f3_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [31:0]         mem_q [2**ADDR_W];

    logic                req, legal, from_bus, do_access, mem_we;
    logic                acc_mr, acc_mw;
    logic [2:0]          acc_f3;
    logic [ADDR_W+1:0]   acc_addr;
    logic [31:0]         acc_wdata;
    logic [ADDR_W-1:0]   idx;
    logic [1:0]          lane;
    logic [31:0]         rd_word, load_val, wd_lanes;
    logic [7:0]          rd_byte;
    logic [15:0]         rd_half;
    logic [3:0]          be;
    logic                unused_addr_hi;

    assign unused_addr_hi = ^bus.addr[31:ADDR_W+2];

    assign req = bus.MR | bus.MW;

    always_comb begin
        legal = 1'b1;
        if (bus.MR && bus.MW) legal = 1'b0;
        if (bus.MR && (bus.func3 == 3'b011 || bus.func3 == 3'b110 || bus.func3 == 3'b111))
            legal = 1'b0;
        if (bus.MW && (bus.func3[2] || bus.func3[1:0] == 2'b11)) legal = 1'b0;
        if (bus.func3[1:0] == 2'b01 && bus.addr[0]) legal = 1'b0;
        if (bus.func3[1:0] == 2'b10 && bus.addr[1:0] != 2'b00) legal = 1'b0;
    end

    // With WAIT_CYCLES=0 the access is performed from the live bus in IDLE.
    assign from_bus  = (state_q == IDLE);
    assign acc_mr    = from_bus ? bus.MR : mr_q;
    assign acc_mw    = from_bus ? bus.MW : mw_q;
    assign acc_f3    = from_bus ? bus.func3 : f3_q;
    assign acc_addr  = from_bus ? bus.addr[ADDR_W+1:0] : addr_q;
    assign acc_wdata = from_bus ? bus.wdata : wdata_q;

    assign idx     = acc_addr[ADDR_W+1:2];
    assign lane    = acc_addr[1:0];
    assign rd_word = mem_q[idx];
    assign rd_byte = rd_word[{lane, 3'b000} +: 8];
    assign rd_half = rd_word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        load_val = rd_word;
        be       = 4'b1111;
        wd_lanes = acc_wdata;
        case (acc_f3)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b100:  load_val = {24'd0, rd_byte};
            3'b101:  load_val = {16'd0, rd_half};
            default: load_val = rd_word;
        endcase
        case (acc_f3[1:0])
            2'b00: begin
                be       = 4'b0001 << lane;
                wd_lanes = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                be       = lane[1] ? 4'b1100 : 4'b0011;
                wd_lanes = {2{acc_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mr_d      = mr_q;
        mw_d      = mw_q;
        f3_d      = f3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        do_access = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    mr_d    = bus.MR;
                    mw_d    = bus.MW;
                    f3_d    = bus.func3;
                    addr_d  = bus.addr[ADDR_W+1:0];
                    wdata_d = bus.wdata;
                    if (!legal) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = 32'd0;
                    end else if (WAIT_CYCLES == 0) begin
                        do_access = 1'b1;
                        state_d   = DONE;
                        err_d     = 1'b0;
                        rdata_d   = acc_mr ? load_val : 32'd0;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    do_access = 1'b1;
                    state_d   = DONE;
                    err_d     = 1'b0;
                    rdata_d   = acc_mr ? load_val : 32'd0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_we = do_access & acc_mw;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Reset on the performing edge suppresses the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wd_lanes[8*b +: 8];
            end
        end
    end

    assign bus.ready = (state_q == DONE);
    assign bus.stall = (state_q == IDLE) ? req : (state_q == BUSY);
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_dmem_resp.sv
// Randomized and directed checks of dmem_resp against a word-array reference model.
module tb_dmem_resp;
    localparam int ADDR_W    = 10;
    localparam int W         = 2;
    localparam int MEM_WORDS = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    logic [31:0] mem_m [MEM_WORDS];

    dmem_resp_if bus();

    dmem_resp #(.ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit legal_m(bit mr, bit mw, logic [2:0] f3, logic [31:0] a);
        int sz;
        sz = f3 % 4;
        if (mr && mw) return 0;
        if (mr && !(f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)) return 0;
        if (mw && !(f3 == 0 || f3 == 1 || f3 == 2)) return 0;
        if (sz == 1 && a % 2 != 0) return 0;
        if (sz == 2 && a % 4 != 0) return 0;
        return 1;
    endfunction

    task automatic ref_op(input bit mr, input bit mw, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] exp_rd, output bit exp_err);
        int          wi, lane;
        logic [31:0] word, b, h, mask;
        exp_rd  = 0;
        exp_err = !legal_m(mr, mw, f3, a);
        if (exp_err) return;
        wi   = int'((a >> 2) % MEM_WORDS);
        lane = int'(a % 4);
        word = mem_m[wi];
        b    = (word >> (8 * lane)) & 32'hFF;
        h    = (word >> (8 * lane)) & 32'hFFFF;
        if (mr) begin
            case (f3)
                3'd0: exp_rd = (b >= 128) ? b - 256 : b;
                3'd1: exp_rd = (h >= 32768) ? h - 65536 : h;
                3'd4: exp_rd = b;
                3'd5: exp_rd = h;
                default: exp_rd = word;
            endcase
        end else begin
            case (f3)
                3'd0: begin
                    mask = 32'hFF << (8 * lane);
                    word = (word & ~mask) | ((wd & 32'hFF) << (8 * lane));
                end
                3'd1: begin
                    mask = 32'hFFFF << (8 * lane);
                    word = (word & ~mask) | ((wd & 32'hFFFF) << (8 * lane));
                end
                default: word = wd;
            endcase
            mem_m[wi] = word;
        end
    endtask

    // Caller guarantees the DUT is in IDLE, sampled #1 after a rising edge.
    task automatic do_op(input string tag, input bit mr, input bit mw, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
        logic [31:0] exp_rd;
        bit          exp_err;
        int          n, stalls, exp_lat;
        ref_op(mr, mw, f3, a, wd, exp_rd, exp_err);
        exp_lat   = exp_err ? 1 : 1 + W;
        bus.MR    = mr;
        bus.MW    = mw;
        bus.func3 = f3;
        bus.addr  = a;
        bus.wdata = wd;
        #1;
        stalls = bus.stall ? 1 : 0;
        n = 0;
        while (n < 30) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.ready) break;
            if (bus.stall) stalls++;
        end
        chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_stalls"}, stalls, exp_lat);
        chk({tag, "_stall_done"}, 32'(bus.stall), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'(exp_err));
        chk({tag, "_rdata"}, bus.rdata, exp_rd);
        got    = bus.rdata;
        bus.MR = 0;
        bus.MW = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] got;
        int          ready_cyc [$];
        int          stall_between;
        bit          seen_ready;

        bus.MR = 0; bus.MW = 0; bus.func3 = 0; bus.addr = 0; bus.wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.ready), 0);
        chk("rst_stall", 32'(bus.stall), 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_err", 32'(bus.err), 0);
        rst = 0;

        for (int i = 0; i < MEM_WORDS; i++) begin
            mem_m[i] = 0;
            do_op("init", 0, 1, 3'b010, 32'(i * 4), 32'd0, got);
        end

        do_op("t1_sw", 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, got);
        do_op("t1_lw", 1, 0, 3'b010, 32'h10, 0, got);
        chk("t1_lw_lit", got, 32'hDEADBEEF);

        do_op("t2_sb", 0, 1, 3'b000, 32'h13, 32'h80, got);
        do_op("t2_lb", 1, 0, 3'b000, 32'h13, 0, got);
        chk("t2_lb_lit", got, 32'hFFFFFF80);
        do_op("t2_lbu", 1, 0, 3'b100, 32'h13, 0, got);
        chk("t2_lbu_lit", got, 32'h00000080);
        do_op("t2_lw", 1, 0, 3'b010, 32'h10, 0, got);
        chk("t2_lw_lit", got, 32'h80ADBEEF);

        do_op("t3_sh", 0, 1, 3'b001, 32'h22, 32'h1234F00D, got);
        do_op("t3_lhu", 1, 0, 3'b101, 32'h22, 0, got);
        chk("t3_lhu_lit", got, 32'h0000F00D);
        do_op("t3_lh", 1, 0, 3'b001, 32'h22, 0, got);
        chk("t3_lh_lit", got, 32'hFFFFF00D);
        do_op("t3_lw", 1, 0, 3'b010, 32'h20, 0, got);
        chk("t3_lw_lit", got, 32'hF00D0000);

        do_op("t4_mis", 1, 0, 3'b010, 32'h11, 0, got);
        do_op("t4_both", 1, 1, 3'b010, 32'h10, 32'h1111_1111, got);
        do_op("t4_f3", 1, 0, 3'b011, 32'h10, 0, got);
        do_op("t4_swf3", 0, 1, 3'b100, 32'h10, 32'h2222_2222, got);
        do_op("t4_unch", 1, 0, 3'b010, 32'h10, 0, got);
        chk("t4_unch_lit", got, 32'h80ADBEEF);

        do_op("t5_pre", 0, 1, 3'b010, 32'h30, 32'h01234567, got);
        for (int k = 0; k < 2; k++) begin
            seen_ready = 0;
            bus.MR = 0; bus.MW = 1; bus.func3 = 3'b010; bus.addr = 32'h30; bus.wdata = 32'h55AA55AA;
            #1;
            chk("t5_stall", 32'(bus.stall), 1);
            for (int c = 0; c <= k; c++) begin
                @(posedge clk);
                #1;
                if (bus.ready) seen_ready = 1;
            end
            rst = 1;
            bus.MW = 0;
            @(posedge clk);
            #1;
            rst = 0;
            chk("t5_idle_stall", 32'(bus.stall), 0);
            chk("t5_rdata", bus.rdata, 0);
            repeat (4) begin
                @(posedge clk);
                #1;
                if (bus.ready) seen_ready = 1;
            end
            chk("t5_no_ready", 32'(seen_ready), 0);
            do_op("t5_lw", 1, 0, 3'b010, 32'h30, 0, got);
            chk("t5_lw_lit", got, 32'h01234567);
        end

        do_op("t6_wrap", 0, 1, 3'b010, 32'h1000, 32'hCAFEF00D, got);
        do_op("t6_lw0", 1, 0, 3'b010, 32'h0, 0, got);
        chk("t6_lw0_lit", got, 32'hCAFEF00D);

        stall_between = 0;
        bus.MR = 1; bus.MW = 0; bus.func3 = 3'b010; bus.addr = 32'h0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            #1;
            if (bus.ready) begin
                ready_cyc.push_back(c);
                chk("t6_b2b_rdata", bus.rdata, mem_m[0]);
                if (ready_cyc.size() == 2) break;
            end else if (bus.stall && ready_cyc.size() == 1) begin
                stall_between++;
            end
        end
        bus.MR = 0;
        @(posedge clk);
        #1;
        chk("t6_b2b_count", ready_cyc.size(), 2);
        if (ready_cyc.size() == 2) begin
            chk("t6_b2b_first", ready_cyc[0], 1 + W);
            chk("t6_b2b_second", ready_cyc[1], 2 * (1 + W) + 1);
        end
        chk("t6_b2b_stalls", stall_between, W + 1);

        for (int i = 0; i < 400; i++) begin
            int          sel;
            bit          mr, mw;
            logic [2:0]  f3;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            mr  = (sel <= 5);
            mw  = (sel == 0) || (sel >= 6);
            f3  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0 && mw && !mr) f3 = 3'($urandom_range(0, 2));
            a = $urandom & 32'hFFFF_F03F;
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            end
            do_op("rnd", mr, mw, f3, a, $urandom, got);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
